axi_write_slave: RTL and testbench
==================================

AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

Interface
REQ-001 SHALL have parameter buswidth, default 32, meaning the data bus width in bits; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of buswidth-bit words in the backing memory.
REQ-003 SHALL have these ports, in this order:
- devclock  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; synchronous, active-low.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  4/32/4/3/2  write address channel.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WID/WDATA/WSTRB/WLAST/WVALID  in  4/buswidth/4/1/1  write data channel.
- WREADY  out  1  data ready.
- BID/BRESP  out  4/2  write response.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- rd_addr  in  6  device-side read word index.
- rd_data  out  buswidth  device-side read data.

Function
REQ-004 SHALL implement a registered FSM with states IDLE, DATA and RESP, and SHALL allow one outstanding transaction.
REQ-005 In IDLE, AWREADY SHALL be 1. On AWVALID&&AWREADY the block SHALL latch AWID, AWADDR[7:2] as the word index, AWLEN, AWSIZE and AWBURST, clear the beat counter and error flags, and go to DATA next cycle.
REQ-006 AWREADY SHALL be 0 in DATA and RESP.
REQ-007 In DATA, WREADY SHALL be 1. Each WVALID&&WREADY beat SHALL increment the 4-bit beat counter.
REQ-008 The burst SHALL be AWLEN+1 beats. The beat where the counter equals the latched AWLEN SHALL end DATA, and the FSM SHALL go to RESP next cycle.
REQ-009 Each accepted beat SHALL write byte lane k of the current word only where WSTRB[k]=1; write latency is 1 cycle.
REQ-010 INCR (2'b01) SHALL advance the word index by 1 per beat. FIXED (2'b00) SHALL hold the word index.
REQ-011 Errors SHALL be detected per beat and SHALL be sticky across the burst:
- WRAP (2'b10), reserved (2'b11), or AWSIZE!=3'd2: SLVERR (2'b10), and every write in the burst SHALL be suppressed.
- WID differs from latched AWID: SLVERR for that beat, and that write SHALL be suppressed.
- WLAST=1 on a non-final beat, or WLAST=0 on the final beat: SLVERR; the burst SHALL still end by beat count.
- AWADDR[31:8]!=0, or word index past DEPTH-1 during INCR: DECERR (2'b11), and that beat's write SHALL be suppressed. The word index SHALL NOT wrap to 0.
REQ-012 Response priority SHALL be DECERR > SLVERR > OKAY (2'b00).
REQ-013 In RESP, BVALID SHALL be 1, BID SHALL equal the latched AWID, and BRESP SHALL be the sticky response. BID and BRESP SHALL be held stable until BVALID&&BREADY, after which the FSM SHALL return to IDLE.
REQ-014 After a response completes, a new AW handshake SHALL be accepted no earlier than the following cycle in IDLE.
REQ-015 WVALID while not in DATA SHALL be ignored: WREADY=0 and there SHALL be no memory effect.
REQ-016 rd_data SHALL equal mem[rd_addr] registered, with 1-cycle latency. A same-cycle write to the same word SHALL return the old data.
REQ-017 BREADY held high before BVALID SHALL complete the handshake in the first RESP cycle.

Reset
REQ-018 While ARESETn=0 at a devclock edge, the block SHALL set: state=IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, rd_data=0, beat counter=0, error flags=0, and all memory words=0.
REQ-019 AWREADY SHALL be 1 in the first cycle after reset is released.
REQ-020 Reset asserted mid-burst or mid-response SHALL abort the transaction without issuing a response.

Structure
REQ-021 Package axi_pkg SHALL hold:
- the response codes OKAY/EXOKAY/SLVERR/DECERR;
- the burst codes FIXED/INCR/WRAP;
- the FSM state encoding for IDLE/DATA/RESP.
REQ-022 A single sub-module, axi_wslave_mem, SHALL hold the DEPTH x buswidth memory with a byte-strobe write port, a registered read port, and synchronous clear on reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- INCR burst: AWADDR=0x10, AWLEN=3, AWID=5, WSTRB=4'hF, data A0..A3 -> words 4..7=A0..A3, BID=5, BRESP=OKAY.
- FIXED burst: AWADDR=0x20, AWLEN=2, WSTRB 4'h1/4'h2/4'h4, data 0x11111111/0x22222222/0x33333333 -> word 8 = 0x00332211, BRESP=OKAY.
- Overrun: AWADDR=0xF8, AWLEN=3, INCR -> words 62,63 written; words 0,1 unchanged; BRESP=DECERR.
- WID mismatch: AWID=2 and WID=3 on beat 1 of 2 -> beat 1 not written, beat 0 written, BRESP=SLVERR, BID=2.
- Backpressure: BREADY held 0 for 5 cycles -> BVALID, BID, BRESP stable and AWREADY=0 throughout; IDLE one cycle after BREADY=1.
- Mid-burst reset: ARESETn=0 after beat 1 of AWLEN=3 -> BVALID never asserts, memory cleared, AWREADY=1 one cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI write-slave definitions: response/burst codes, FSM encoding,
// latched write-address payload and response priority helper.
package axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned IDX_W  = 6;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             hi_err;
    } aw_req_t;

    // DECERR outranks SLVERR, which outranks OKAY.
    function automatic logic [1:0] resolve_resp(input logic dec, input logic slv);
        if (dec) return DECERR;
        if (slv) return SLVERR;
        return OKAY;
    endfunction

endpackage

// File: rtl/axi_wslave_mem.sv
// Word memory with byte-strobe write port, registered read port and
// synchronous clear on reset. Reads return pre-write data on collision.
module axi_wslave_mem #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
            if (we) begin
                for (int b = 0; b < int'(DW / 8); b++) begin
                    if (wstrb[b]) begin
                        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi_write_slave.sv
// Single-outstanding AXI3 write slave backed by a word memory, with sticky
// per-burst error tracking and a device-side read port.
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int unsigned buswidth = 32,
    parameter int unsigned DEPTH    = 64
) (
    input  logic                devclock,
    input  logic                ARESETn,
    input  logic [3:0]          AWID,
    input  logic [31:0]         AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [3:0]          WID,
    input  logic [buswidth-1:0] WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [3:0]          BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [5:0]          rd_addr,
    output logic [buswidth-1:0] rd_data
);

    state_e            state_q, state_d;
    aw_req_t           aw_q;
    logic [LEN_W-1:0]  beat_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ovf_q, slverr_q, decerr_q;
    logic              awready_d, wready_d, bvalid_d;

    logic aw_hs, w_hs, last_beat, final_hs;
    logic burst_err, id_err, last_err, in_range, dec_now, slv_now, mem_we;
    logic unused_addr_bits;

    assign unused_addr_bits = ^AWADDR[1:0];

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign last_beat = (beat_q == aw_q.len);
    assign final_hs  = w_hs && last_beat;

    // Per-beat error classification; a bad burst type/size poisons every beat.
    assign burst_err = (aw_q.burst == WRAP) || (aw_q.burst == 2'b11) || (aw_q.size != 3'd2);
    assign id_err    = (WID != aw_q.id);
    assign last_err  = (WLAST != last_beat);
    assign in_range  = ({1'b0, idx_q} <= 7'(DEPTH - 1));
    assign dec_now   = aw_q.hi_err || ovf_q || !in_range;
    assign slv_now   = burst_err || id_err || last_err;
    assign mem_we    = w_hs && !burst_err && !id_err && !dec_now;

    // State register plus registered handshake outputs.
    always_ff @(posedge devclock) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
        end else begin
            state_q <= state_d;
            AWREADY <= awready_d;
            WREADY  <= wready_d;
            BVALID  <= bvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_hs) state_d = DATA;
            DATA:    if (final_hs) state_d = RESP;
            RESP:    if (BVALID && BREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they line up with it.
    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        case (state_d)
            IDLE:    awready_d = 1'b1;
            DATA:    wready_d  = 1'b1;
            RESP:    bvalid_d  = 1'b1;
            default: awready_d = 1'b0;
        endcase
    end

    // Address latch, beat counter, word index and sticky error flags.
    always_ff @(posedge devclock) begin
        if (!ARESETn) begin
            aw_q     <= '0;
            beat_q   <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            slverr_q <= 1'b0;
            decerr_q <= 1'b0;
        end else if (aw_hs) begin
            aw_q     <= '{id: AWID, len: AWLEN, size: AWSIZE, burst: AWBURST,
                          hi_err: (AWADDR[31:8] != 24'd0)};
            idx_q    <= AWADDR[7:2];
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            slverr_q <= 1'b0;
            decerr_q <= 1'b0;
        end else if (w_hs) begin
            beat_q   <= beat_q + 4'd1;
            slverr_q <= slverr_q | slv_now;
            decerr_q <= decerr_q | dec_now;
            if (aw_q.burst == INCR) begin
                // Saturate at the top word; later beats decode-error instead of wrapping.
                if ({1'b0, idx_q} >= 7'(DEPTH - 1)) begin
                    ovf_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 6'd1;
                end
            end
        end
    end

    // Response captured on the final beat and held through backpressure.
    always_ff @(posedge devclock) begin
        if (!ARESETn) begin
            BID   <= '0;
            BRESP <= OKAY;
        end else if (final_hs) begin
            BID   <= aw_q.id;
            BRESP <= resolve_resp(decerr_q | dec_now, slverr_q | slv_now);
        end
    end

    axi_wslave_mem #(
        .DW    (buswidth),
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (devclock),
        .rst_n (ARESETn),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (WDATA),
        .wstrb (WSTRB),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: bursts, error responses, backpressure
// and reset behaviour, checked with immediate assertions.
module tb_axi_write_slave;

    logic        devclock;
    logic        ARESETn;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    axi_write_slave #(.buswidth(32), .DEPTH(64)) dut (
        .devclock (devclock),
        .ARESETn  (ARESETn),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WID      (WID),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial devclock = 1'b0;
    always #5 devclock = ~devclock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge devclock);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int k = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size;
        AWVALID = 1'b1;
        while (!AWREADY && k < 20) begin
            tick();
            k++;
        end
        check("awready_wait", 32'(AWREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int k = 0;
        WID = id; WDATA = data; WSTRB = strb; WLAST = last;
        WVALID = 1'b1;
        while (!WREADY && k < 20) begin
            tick();
            k++;
        end
        check("wready_wait", 32'(WREADY), 32'd1);
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int k = 0;
        BREADY = 1'b1;
        while (!BVALID && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
        check({tag, "_bid"}, 32'(BID), 32'(id));
        check({tag, "_bresp"}, 32'(BRESP), 32'(resp));
        tick();
        BREADY = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; rd_addr = '0;

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_bid", 32'(BID), 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        ARESETn = 1'b1;
        tick();
        check("post_rst_awready", 32'(AWREADY), 32'd1);

        // INCR burst: words 4..7
        aw_send(4'd5, 32'h10, 4'd3, 2'b01, 3'd2);
        check("incr_wready_first", 32'(WREADY), 32'd1);
        check("incr_awready_low", 32'(AWREADY), 32'd0);
        for (int i = 0; i < 4; i++) begin
            w_beat(4'd5, 32'hA0 + 32'(i), 4'hF, i == 3);
        end
        check("incr_wready_done", 32'(WREADY), 32'd0);
        get_resp("incr", 4'd5, 2'b00);
        read_word("incr_w3", 6'd3, 32'd0);
        read_word("incr_w4", 6'd4, 32'hA0);
        read_word("incr_w5", 6'd5, 32'hA1);
        read_word("incr_w6", 6'd6, 32'hA2);
        read_word("incr_w7", 6'd7, 32'hA3);
        read_word("incr_w8", 6'd8, 32'd0);

        // FIXED burst with byte strobes into word 8
        aw_send(4'd1, 32'h20, 4'd2, 2'b00, 3'd2);
        w_beat(4'd1, 32'h11111111, 4'h1, 1'b0);
        w_beat(4'd1, 32'h22222222, 4'h2, 1'b0);
        w_beat(4'd1, 32'h33333333, 4'h4, 1'b1);
        get_resp("fixed", 4'd1, 2'b00);
        read_word("fixed_w8", 6'd8, 32'h00332211);
        read_word("fixed_w9", 6'd9, 32'd0);

        // INCR overrun past the top word
        aw_send(4'd7, 32'hF8, 4'd3, 2'b01, 3'd2);
        for (int i = 0; i < 4; i++) begin
            w_beat(4'd7, 32'hB0 + 32'(i), 4'hF, i == 3);
        end
        get_resp("ovr", 4'd7, 2'b11);
        read_word("ovr_w62", 6'd62, 32'hB0);
        read_word("ovr_w63", 6'd63, 32'hB1);
        read_word("ovr_w0", 6'd0, 32'd0);
        read_word("ovr_w1", 6'd1, 32'd0);

        // WID mismatch on the second beat
        aw_send(4'd2, 32'h40, 4'd1, 2'b01, 3'd2);
        w_beat(4'd2, 32'hC0, 4'hF, 1'b0);
        w_beat(4'd3, 32'hC1, 4'hF, 1'b1);
        get_resp("wid", 4'd2, 2'b10);
        read_word("wid_w16", 6'd16, 32'hC0);
        read_word("wid_w17", 6'd17, 32'd0);

        // Unsupported AWSIZE suppresses the whole burst
        aw_send(4'd3, 32'h50, 4'd1, 2'b01, 3'd1);
        w_beat(4'd3, 32'hE0, 4'hF, 1'b0);
        w_beat(4'd3, 32'hE1, 4'hF, 1'b1);
        get_resp("size", 4'd3, 2'b10);
        read_word("size_w20", 6'd20, 32'd0);
        read_word("size_w21", 6'd21, 32'd0);

        // Early WLAST: writes proceed, burst ends by count, SLVERR
        aw_send(4'd4, 32'h60, 4'd1, 2'b01, 3'd2);
        w_beat(4'd4, 32'hF0, 4'hF, 1'b1);
        check("wlast_still_data", 32'(WREADY), 32'd1);
        w_beat(4'd4, 32'hF1, 4'hF, 1'b1);
        get_resp("wlast", 4'd4, 2'b10);
        read_word("wlast_w24", 6'd24, 32'hF0);
        read_word("wlast_w25", 6'd25, 32'hF1);

        // Response backpressure
        aw_send(4'd9, 32'h80, 4'd0, 2'b01, 3'd2);
        w_beat(4'd9, 32'hD0, 4'hF, 1'b1);
        BREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", 32'(BVALID), 32'd1);
            check("bp_bid", 32'(BID), 32'd9);
            check("bp_bresp", 32'(BRESP), 32'd0);
            check("bp_awready", 32'(AWREADY), 32'd0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bp_idle_awready", 32'(AWREADY), 32'd1);
        check("bp_idle_bvalid", 32'(BVALID), 32'd0);

        // Stray WVALID in IDLE has no effect
        WID = 4'd9; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
        check("stray_wready", 32'(WREADY), 32'd0);
        tick(); tick();
        WVALID = 1'b0;
        read_word("stray_w32", 6'd32, 32'hD0);
        read_word("stray_w33", 6'd33, 32'd0);

        // Reset after beat 1 of a 4-beat burst
        aw_send(4'd6, 32'h30, 4'd3, 2'b01, 3'd2);
        w_beat(4'd6, 32'h60, 4'hF, 1'b0);
        w_beat(4'd6, 32'h61, 4'hF, 1'b0);
        BREADY = 1'b1;
        ARESETn = 1'b0;
        tick(); tick();
        check("mrst_awready_low", 32'(AWREADY), 32'd0);
        check("mrst_bvalid_low", 32'(BVALID), 32'd0);
        ARESETn = 1'b1;
        tick();
        check("mrst_awready", 32'(AWREADY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("mrst_no_bvalid", 32'(BVALID), 32'd0);
            tick();
        end
        BREADY = 1'b0;
        read_word("mrst_w4", 6'd4, 32'd0);
        read_word("mrst_w12", 6'd12, 32'd0);
        read_word("mrst_w62", 6'd62, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
